// File: rtl/blake3_block_sequencer.sv
// BLAKE3 single-chunk block sequencer: packs a little-endian 32-bit word stream into
// 64-byte blocks, drives HashGen one block at a time with chaining and flags, emits the root digest.

module blake3_word_slot #(
  parameter int VEC_W = 32
) (
  input  logic             Clk,
  input  logic             RstN_I,
  input  logic             we,
  input  logic             clr,
  input  logic [VEC_W-1:0] wdata,
  output logic [VEC_W-1:0] word
);
  always_ff @(posedge Clk or negedge RstN_I) begin
    if (!RstN_I)   word <= '0;
    else if (clr)  word <= '0;
    else if (we)   word <= wdata;
  end
endmodule

module blake3_block_sequencer #(
  parameter int MAX_BLOCKS = 16
) (
  input  logic             Clk,
  input  logic             RstN_I,
  input  logic             Wr_I,
  input  logic [31:0]      WrData_I,
  input  logic             Last_I,
  input  logic [2:0]       LastBytes_I,
  output logic             Rdy_O,
  output logic             Hg_Strt_O,
  output logic [31:0]      Hg_BL_O,
  output logic             Hg_CS_O,
  output logic             Hg_CE_O,
  output logic             Hg_ROOT_O,
  output logic [7:0][31:0] Hg_H_O,
  output logic [15:0][31:0] Hg_Msg_O,
  input  logic             Hg_Vld_I,
  input  logic [7:0][31:0] Hg_H_I,
  output logic             Vld_O,
  output logic [7:0][31:0] Digest_O,
  output logic             Ovf_O
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 32;
  localparam int BIW       = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [7:0][VEC_W-1:0] IV = {
    32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  typedef enum logic [1:0] {FILL, START, WAIT} state_t;

  state_t                          state_q, state_d;
  logic                            rdy_q, drop_q, final_q, ovf_q, vld_q;
  logic [3:0]                      word_idx_q;
  logic [6:0]                      byte_cnt_q;
  logic [BIW-1:0]                  blk_idx_q;
  logic [7:0][VEC_W-1:0]           cv_q, digest_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] msg;

  logic             accept, take, blk_end, last_blk, blk_done;
  logic [2:0]       lb;
  logic [VEC_W-1:0] wmask, wword;

  // rdy_q is high only while in FILL, so accept implies FILL
  assign accept   = Wr_I && rdy_q;
  assign take     = accept && !drop_q;
  assign blk_end  = take && (Last_I || word_idx_q == 4'(NUM_LANES-1));
  assign last_blk = (blk_idx_q == BIW'(MAX_BLOCKS-1));
  assign blk_done = (state_q == WAIT) && Hg_Vld_I;
  assign lb       = (LastBytes_I == 3'd0 || LastBytes_I > 3'd4) ? 3'd4 : LastBytes_I;

  always_comb begin
    wmask = '1;
    if (Last_I) begin
      case (lb)
        3'd1:    wmask = 32'h0000_00FF;
        3'd2:    wmask = 32'h0000_FFFF;
        3'd3:    wmask = 32'h00FF_FFFF;
        default: wmask = '1;
      endcase
    end
  end
  assign wword = WrData_I & wmask;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    blake3_word_slot #(.VEC_W(VEC_W)) u_slot (
      .Clk    (Clk),
      .RstN_I (RstN_I),
      .we     (take && (word_idx_q == 4'(i))),
      .clr    (blk_done),
      .wdata  (wword),
      .word   (msg[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (blk_end) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (Hg_Vld_I) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN_I) begin
    if (!RstN_I) begin
      state_q    <= FILL;
      rdy_q      <= 1'b0;
      drop_q     <= 1'b0;
      final_q    <= 1'b0;
      ovf_q      <= 1'b0;
      vld_q      <= 1'b0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      blk_idx_q  <= '0;
      cv_q       <= IV;
      digest_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == FILL);
      vld_q   <= 1'b0;
      // truncated tail: swallow words up to and including the terminating Last_I
      if (accept && drop_q && Last_I) drop_q <= 1'b0;
      if (take) begin
        word_idx_q <= word_idx_q + 4'd1;
        byte_cnt_q <= byte_cnt_q + (Last_I ? {4'd0, lb} : 7'd4);
      end
      if (blk_end) begin
        final_q <= Last_I || last_blk;
        ovf_q   <= !Last_I && last_blk;
      end
      if (blk_done) begin
        word_idx_q <= '0;
        byte_cnt_q <= '0;
        final_q    <= 1'b0;
        ovf_q      <= 1'b0;
        if (final_q) begin
          digest_q  <= Hg_H_I;
          vld_q     <= 1'b1;
          cv_q      <= IV;
          blk_idx_q <= '0;
          drop_q    <= ovf_q;
        end else begin
          cv_q      <= Hg_H_I;
          blk_idx_q <= blk_idx_q + BIW'(1);
        end
      end
    end
  end

  assign Rdy_O     = rdy_q;
  assign Hg_Strt_O = (state_q == START);
  assign Hg_BL_O   = {25'd0, byte_cnt_q};
  assign Hg_CS_O   = (state_q != FILL) && (blk_idx_q == '0);
  assign Hg_CE_O   = final_q;
  assign Hg_ROOT_O = final_q;
  assign Hg_H_O    = cv_q;
  assign Hg_Msg_O  = msg;
  assign Vld_O     = vld_q;
  assign Digest_O  = digest_q;
  assign Ovf_O     = (state_q == START) && ovf_q;
endmodule

// File: tb/tb_blake3_block_sequencer.sv
// Bench for blake3_block_sequencer: a BLAKE3 compression responder stands in for HashGen,
// and a byte-level message model predicts every block descriptor and the root digest.

module tb_blake3_block_sequencer;
  localparam logic [7:0][31:0] IV = {
    32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam logic [7:0][31:0] ABC_DIG = {
    32'h859dbdd5, 32'h6c9c35fd, 32'h03db795d, 32'h4658c548,
    32'hb58d3a27, 32'h753bb6ff, 32'h33514638, 32'hacb33764};
  localparam int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  typedef struct {
    logic [31:0]       bl;
    logic              cs, ce, root;
    logic [7:0][31:0]  h;
    logic [15:0][31:0] m;
  } blk_t;

  logic              Clk = 1'b0, RstN_I = 1'b0;
  logic              Wr_I = 1'b0, Last_I = 1'b0;
  logic [31:0]       WrData_I = '0;
  logic [2:0]        LastBytes_I = '0;
  logic              Rdy_O, Hg_Strt_O, Hg_CS_O, Hg_CE_O, Hg_ROOT_O, Vld_O, Ovf_O;
  logic [31:0]       Hg_BL_O;
  logic [7:0][31:0]  Hg_H_O, Digest_O;
  logic [15:0][31:0] Hg_Msg_O;
  logic              Hg_Vld_I = 1'b0;
  logic [7:0][31:0]  Hg_H_I = '0;

  blake3_block_sequencer #(.MAX_BLOCKS(16)) dut (
    .Clk(Clk), .RstN_I(RstN_I), .Wr_I(Wr_I), .WrData_I(WrData_I), .Last_I(Last_I),
    .LastBytes_I(LastBytes_I), .Rdy_O(Rdy_O), .Hg_Strt_O(Hg_Strt_O), .Hg_BL_O(Hg_BL_O),
    .Hg_CS_O(Hg_CS_O), .Hg_CE_O(Hg_CE_O), .Hg_ROOT_O(Hg_ROOT_O), .Hg_H_O(Hg_H_O),
    .Hg_Msg_O(Hg_Msg_O), .Hg_Vld_I(Hg_Vld_I), .Hg_H_I(Hg_H_I), .Vld_O(Vld_O),
    .Digest_O(Digest_O), .Ovf_O(Ovf_O));

  always #5 Clk = ~Clk;

  int tests = 0, fails = 0;
  int vld_cnt = 0, ovf_cnt = 0, rdy_bad = 0, stab_bad = 0;
  int resp_lo = 0, resp_hi = 3;
  logic [7:0][31:0] last_dig = '0;
  blk_t log_q[$];
  blk_t exp_q[$];
  logic [7:0][31:0] exp_dig;
  bit exp_ovf;
  logic [31:0] msg_q[$];
  int msg_lb;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [15:0][31:0] gmix(input logic [15:0][31:0] vi, input int a, b, c, d,
                                             input logic [31:0] x, y);
    logic [15:0][31:0] v;
    v = vi;
    v[a] = v[a] + v[b] + x; v[d] = ror(v[d] ^ v[a], 16);
    v[c] = v[c] + v[d];     v[b] = ror(v[b] ^ v[c], 12);
    v[a] = v[a] + v[b] + y; v[d] = ror(v[d] ^ v[a], 8);
    v[c] = v[c] + v[d];     v[b] = ror(v[b] ^ v[c], 7);
    return v;
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] h, input logic [15:0][31:0] m,
                                                input logic [31:0] bl, input logic [31:0] flags);
    logic [15:0][31:0] v, mw, t;
    logic [7:0][31:0]  o;
    for (int i = 0; i < 8; i++) begin
      v[i]   = h[i];
      v[i+8] = (i < 4) ? IV[i] : 32'h0;
    end
    v[14] = bl;
    v[15] = flags;
    mw = m;
    for (int r = 0; r < 7; r++) begin
      v = gmix(v, 0, 4,  8, 12, mw[0],  mw[1]);
      v = gmix(v, 1, 5,  9, 13, mw[2],  mw[3]);
      v = gmix(v, 2, 6, 10, 14, mw[4],  mw[5]);
      v = gmix(v, 3, 7, 11, 15, mw[6],  mw[7]);
      v = gmix(v, 0, 5, 10, 15, mw[8],  mw[9]);
      v = gmix(v, 1, 6, 11, 12, mw[10], mw[11]);
      v = gmix(v, 2, 7,  8, 13, mw[12], mw[13]);
      v = gmix(v, 3, 4,  9, 14, mw[14], mw[15]);
      for (int i = 0; i < 16; i++) t[i] = mw[PERM[i]];
      mw = t;
    end
    for (int i = 0; i < 8; i++) o[i] = v[i] ^ v[i+8];
    return o;
  endfunction

  // HashGen stand-in plus bookkeeping; sometimes raises a junk Hg_Vld_I in the START cycle
  blk_t cap;
  logic [7:0][31:0] res;
  int  dly = 0;
  bit  busy = 0;
  always @(negedge Clk) begin
    if (!RstN_I) begin
      busy = 0;
      Hg_Vld_I = 1'b0;
    end else begin
      if (Vld_O) begin vld_cnt++; last_dig = Digest_O; end
      if (Ovf_O) ovf_cnt++;
      if (busy) begin
        if (Rdy_O) rdy_bad++;
        if (Hg_BL_O !== cap.bl || Hg_CS_O !== cap.cs || Hg_CE_O !== cap.ce ||
            Hg_ROOT_O !== cap.root || Hg_H_O !== cap.h || Hg_Msg_O !== cap.m) stab_bad++;
        if (dly == 0) begin Hg_Vld_I = 1'b1; Hg_H_I = res; busy = 0; end
        else begin Hg_Vld_I = 1'b0; dly--; end
      end else begin
        Hg_Vld_I = 1'b0;
        if (Hg_Strt_O) begin
          if (Rdy_O) rdy_bad++;
          cap.bl = Hg_BL_O; cap.cs = Hg_CS_O; cap.ce = Hg_CE_O; cap.root = Hg_ROOT_O;
          cap.h = Hg_H_O; cap.m = Hg_Msg_O;
          log_q.push_back(cap);
          res  = compress(Hg_H_O, Hg_Msg_O, Hg_BL_O, {28'd0, Hg_ROOT_O, 1'b0, Hg_CE_O, Hg_CS_O});
          busy = 1;
          dly  = $urandom_range(resp_hi, resp_lo);
          if ($urandom_range(1, 0) == 1) begin
            Hg_Vld_I = 1'b1;
            Hg_H_I   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          end
        end
      end
    end
  end

  // Reference: byte stream, truncated to one chunk, split into 64-byte blocks, chained
  task automatic build_model();
    logic [7:0] bytes[$];
    logic [7:0][31:0]  h;
    logic [15:0][31:0] m;
    blk_t e;
    int lbe, len, nb, bl;
    lbe = (msg_lb == 0 || msg_lb > 4) ? 4 : msg_lb;
    for (int i = 0; i < msg_q.size(); i++)
      for (int k = 0; k < 4; k++)
        if (i < msg_q.size() - 1 || k < lbe) bytes.push_back(msg_q[i][8*k +: 8]);
    exp_ovf = bytes.size() > 1024;
    while (bytes.size() > 1024) void'(bytes.pop_back());
    len = bytes.size();
    nb  = (len + 63) / 64;
    h   = IV;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      bl = (len - 64*b > 64) ? 64 : len - 64*b;
      m  = '0;
      for (int j = 0; j < bl; j++) m[j/4][8*(j%4) +: 8] = bytes[64*b + j];
      e.bl = bl; e.cs = (b == 0); e.ce = (b == nb - 1); e.root = (b == nb - 1);
      e.h = h; e.m = m;
      exp_q.push_back(e);
      h = compress(h, m, bl, {28'd0, e.root, 1'b0, e.ce, e.cs});
    end
    exp_dig = h;
  endtask

  task automatic fill_rand(input int n, input int lb);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back($urandom);
    msg_lb = lb;
  endtask

  task automatic put_word(input logic [31:0] w, input bit last, input logic [2:0] lb, input bit gaps);
    bit acc;
    int n;
    n = 0;
    if (gaps && $urandom_range(3, 0) == 0) begin Wr_I = 1'b0; @(negedge Clk); end
    Wr_I = 1'b1; WrData_I = w; Last_I = last;
    LastBytes_I = last ? lb : 3'($urandom);
    do begin acc = Rdy_O; @(negedge Clk); n++; end while (!acc && n < 5000);
    Wr_I = 1'b0; Last_I = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL put_word: word %h not accepted within %0d cycles", w, n);
    end
  endtask

  task automatic run_msg(input string name, input bit gaps);
    int v0, o0, l0, rb0, sb0, n;
    v0 = vld_cnt; o0 = ovf_cnt; l0 = log_q.size(); rb0 = rdy_bad; sb0 = stab_bad;
    build_model();
    for (int i = 0; i < msg_q.size(); i++) put_word(msg_q[i], i == msg_q.size() - 1, 3'(msg_lb), gaps);
    n = 0;
    while (vld_cnt == v0 && n < 3000) begin @(negedge Clk); n++; end
    repeat (10) @(negedge Clk);
    tests++;
    if (vld_cnt - v0 != 1) begin fails++; $display("FAIL %s vld_count: got %0d want 1", name, vld_cnt - v0); end
    tests++;
    if (log_q.size() - l0 != exp_q.size()) begin
      fails++; $display("FAIL %s start_count: got %0d want %0d", name, log_q.size() - l0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (l0 + i < log_q.size()) begin
        tests++;
        if (log_q[l0+i].bl !== exp_q[i].bl || log_q[l0+i].cs !== exp_q[i].cs ||
            log_q[l0+i].ce !== exp_q[i].ce || log_q[l0+i].root !== exp_q[i].root) begin
          fails++;
          $display("FAIL %s blk%0d hdr: got bl=%0d cs=%b ce=%b root=%b want bl=%0d cs=%b ce=%b root=%b",
                   name, i, log_q[l0+i].bl, log_q[l0+i].cs, log_q[l0+i].ce, log_q[l0+i].root,
                   exp_q[i].bl, exp_q[i].cs, exp_q[i].ce, exp_q[i].root);
        end
        tests++;
        if (log_q[l0+i].h !== exp_q[i].h) begin
          fails++; $display("FAIL %s blk%0d cv: got %h want %h", name, i, log_q[l0+i].h, exp_q[i].h);
        end
        tests++;
        if (log_q[l0+i].m !== exp_q[i].m) begin
          fails++; $display("FAIL %s blk%0d msg: got %h want %h", name, i, log_q[l0+i].m, exp_q[i].m);
        end
      end
    end
    tests++;
    if (last_dig !== exp_dig) begin fails++; $display("FAIL %s digest: got %h want %h", name, last_dig, exp_dig); end
    tests++;
    if (ovf_cnt - o0 != (exp_ovf ? 1 : 0)) begin
      fails++; $display("FAIL %s ovf_count: got %0d want %0d", name, ovf_cnt - o0, exp_ovf ? 1 : 0);
    end
    tests++;
    if (rdy_bad != rb0 || stab_bad != sb0) begin
      fails++; $display("FAIL %s handshake: rdy_while_busy=%0d unstable=%0d want 0 0", name, rdy_bad - rb0, stab_bad - sb0);
    end
  endtask

  task automatic test_reset();
    RstN_I = 1'b0;
    repeat (3) @(negedge Clk);
    tests++;
    if (Rdy_O !== 1'b0 || Hg_Strt_O !== 1'b0 || Vld_O !== 1'b0 || Ovf_O !== 1'b0 ||
        Hg_CS_O !== 1'b0 || Hg_CE_O !== 1'b0 || Hg_ROOT_O !== 1'b0 || Hg_BL_O !== 32'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b strt=%b vld=%b ovf=%b cs=%b ce=%b root=%b bl=%0d want all 0",
               Rdy_O, Hg_Strt_O, Vld_O, Ovf_O, Hg_CS_O, Hg_CE_O, Hg_ROOT_O, Hg_BL_O);
    end
    tests++;
    if (Hg_H_O !== IV || Digest_O !== '0 || Hg_Msg_O !== '0) begin
      fails++; $display("FAIL reset_data: got h=%h dig=%h want h=%h dig=0 msg=0", Hg_H_O, Digest_O, IV);
    end
    RstN_I = 1'b1;
    @(negedge Clk);
    tests++;
    if (Rdy_O !== 1'b1) begin fails++; $display("FAIL reset_release_rdy: got %b want 1", Rdy_O); end
  endtask

  task automatic test_abc();
    msg_q.delete(); msg_q.push_back(32'hFF636261); msg_lb = 3;
    run_msg("abc", 0);
    tests++;
    if (last_dig !== ABC_DIG) begin fails++; $display("FAIL abc_known_digest: got %h want %h", last_dig, ABC_DIG); end
  endtask

  task automatic test_exact_block();
    fill_rand(16, 0);
    run_msg("exact_block", 1);
  endtask

  task automatic test_two_blocks();
    fill_rand(17, 1);
    run_msg("two_blocks", 1);
  endtask

  task automatic test_full_chunk();
    fill_rand(256, 4);
    run_msg("full_chunk", 0);
  endtask

  task automatic test_overflow();
    fill_rand(260, 2);
    run_msg("overflow", 0);
    fill_rand(5, 3);
    run_msg("after_overflow", 1);
  endtask

  task automatic test_reset_in_wait();
    int v0, l0;
    fill_rand(20, 2);
    resp_lo = 40; resp_hi = 40;
    l0 = log_q.size();
    for (int i = 0; i < 20; i++) put_word(msg_q[i], i == 19, 3'(msg_lb), 0);
    @(negedge Clk);
    v0 = vld_cnt;
    tests++;
    if (log_q.size() - l0 != 2 || Rdy_O !== 1'b0 || Hg_CE_O !== 1'b1) begin
      fails++; $display("FAIL rst_wait_pre: got starts=%0d rdy=%b ce=%b want 2 0 1", log_q.size() - l0, Rdy_O, Hg_CE_O);
    end
    RstN_I = 1'b0;
    #1;
    tests++;
    if (Hg_H_O !== IV || Rdy_O !== 1'b0 || Hg_CE_O !== 1'b0 || Hg_BL_O !== 32'd0) begin
      fails++; $display("FAIL rst_wait_async: got h=%h rdy=%b ce=%b bl=%0d want IV 0 0 0", Hg_H_O, Rdy_O, Hg_CE_O, Hg_BL_O);
    end
    repeat (2) @(negedge Clk);
    RstN_I = 1'b1;
    resp_lo = 0; resp_hi = 3;
    repeat (60) @(negedge Clk);
    tests++;
    if (vld_cnt != v0 || Hg_H_O !== IV) begin
      fails++; $display("FAIL rst_wait_no_vld: got vld_pulses=%0d h=%h want 0 IV", vld_cnt - v0, Hg_H_O);
    end
    fill_rand(1, $urandom_range(4, 1));
    run_msg("after_reset", 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      fill_rand($urandom_range(48, 1), $urandom_range(7, 0));
      run_msg("random", 1);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_exact_block();
    test_two_blocks();
    test_full_chunk();
    test_overflow();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
